pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-low reset, rst_n.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- OP_W, 6, opcode width.
- REG_W, 5, register index width.
- LOAD_LAT, 1, stall cycles per load-use hazard (legal 1..15).
- MD_LAT, 4, mul/div busy cycles (legal 1..31).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- E_op  in  OP_W  opcode of the instruction in Execute.
- E_dstM  in  REG_W  load destination in Execute; `RNONE means no destination.
- D_srcA  in  REG_W  first source register of the instruction in Decode.
- D_srcB  in  REG_W  second source register of the instruction in Decode.
- E_md_start  in  1  Execute launches a multi-cycle mul/div.
- D_uses_md  in  1  Decode instruction reads HI/LO.
- E_br_taken  in  1  branch redirect resolved in Execute.
- F_stall  out  1  hold PC.
- D_stall  out  1  hold D register.
- D_bubble  out  1  flush D register.
- E_bubble  out  1  insert nop into E register.
- md_busy  out  1  mul/div unit occupied.
REQ-004 Opcode and register codes (`ILW, `RNONE) SHALL come from the shared define file.

Function
REQ-005 load_hit SHALL be true when E_op==`ILW, E_dstM!=`RNONE, and E_dstM equals D_srcA or D_srcB.
REQ-006 The FSM SHALL have two states, IDLE and LOAD_WAIT, and a 4-bit counter ld_cnt.
REQ-007 In IDLE with load_hit, the block SHALL assert F_stall, D_stall and E_bubble combinationally in that cycle.
REQ-008 If LOAD_LAT>1 in that case, the FSM SHALL go to LOAD_WAIT and load ld_cnt=LOAD_LAT-1; otherwise it SHALL stay in IDLE.
REQ-009 In LOAD_WAIT, the block SHALL assert F_stall, D_stall and E_bubble and decrement ld_cnt each cycle.
REQ-010 The FSM SHALL return to IDLE in the cycle ld_cnt is 1, so a load-use hazard stalls exactly LOAD_LAT consecutive cycles.
REQ-011 The FSM SHALL ignore load_hit while in LOAD_WAIT, so no stall extension or re-trigger occurs.
REQ-012 E_md_start SHALL load the 5-bit md_cnt with MD_LAT next cycle, including a reload while busy.
REQ-013 When E_md_start is low, md_cnt SHALL decrement if nonzero and saturate at 0.
REQ-014 md_busy SHALL equal (md_cnt!=0).
REQ-015 md_hit SHALL be D_uses_md && (md_busy || E_md_start).
REQ-016 md_hit SHALL assert F_stall, D_stall and E_bubble in the same cycle.
REQ-017 The load stall and the md stall SHALL combine by OR, and each counter SHALL advance independently.
REQ-018 E_br_taken SHALL have highest priority: D_bubble=1, E_bubble=1, F_stall=0, D_stall=0 that cycle.
REQ-019 E_br_taken SHALL force the FSM to IDLE and clear ld_cnt; md_cnt is unaffected.
REQ-020 D_bubble SHALL be 1 only on E_br_taken.
REQ-021 When no hazard or branch is present, all stall and bubble outputs SHALL be 0.
REQ-022 Equality compares SHALL be full REG_W wide, with no sign or width extension.

Reset
REQ-023 While rst_n==0 at a clk edge, the next state SHALL be IDLE, ld_cnt=0 and md_cnt=0.
REQ-024 While rst_n==0, all outputs SHALL read 0 regardless of inputs.
REQ-025 Reset SHALL win over simultaneous E_md_start, load_hit and E_br_taken.
REQ-026 Reset asserted mid-LOAD_WAIT or mid-md-busy SHALL abort the stall, and outputs SHALL be 0 in the first cycle after release unless a new hazard is present.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- LOAD_LAT=1; E_op=`ILW, E_dstM=7, D_srcA=7 -> F_stall/D_stall/E_bubble=1 for 1 cycle, then 0 once E_op becomes nop.
- LOAD_LAT=3; same hit -> stall outputs high exactly 3 cycles, FSM back in IDLE on cycle 4.
- E_op=`ILW with E_dstM=`RNONE, D_srcA=`RNONE; or E_op=`ISW, E_dstM=6, D_srcB=6 -> no stall.
- MD_LAT=4; E_md_start pulse, D_uses_md=1 on the same cycle -> stall 5 cycles total, md_busy high 4 cycles, both 0 afterwards.
- LOAD_LAT=3; E_br_taken during a cycle with D_uses_md=1 and md_busy=1 -> D_bubble=E_bubble=1, F_stall=D_stall=0 that cycle.
- LOAD_LAT=3; rst_n=0 for 1 cycle during the 2nd LOAD_WAIT cycle -> all outputs 0 during reset and after release, ld_cnt=0, md_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use and mul/div interlock with branch-flush priority.
// Rev 1.0 -- initial release.
`ifndef ILW
`define ILW 6'h23
`endif
`ifndef ISW
`define ISW 6'h2b
`endif
`ifndef RNONE
`define RNONE 5'd0
`endif

`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int OP_W     = 6,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  E_op,
  input  logic [REG_W-1:0] E_dstM,
  input  logic [REG_W-1:0] D_srcA,
  input  logic [REG_W-1:0] D_srcB,
  input  logic             E_md_start,
  input  logic             D_uses_md,
  input  logic             E_br_taken,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             md_busy
);

  localparam logic [0:0]       IDLE      = 1'b0;
  localparam logic [0:0]       LOAD_WAIT = 1'b1;
  localparam logic [3:0]       LD_INIT   = 4'(LOAD_LAT - 1);
  localparam logic [4:0]       MD_INIT   = 5'(MD_LAT);
  localparam bit               LD_MULTI  = (LOAD_LAT > 1);
  localparam logic [OP_W-1:0]  OP_LW     = OP_W'(`ILW);
  localparam logic [REG_W-1:0] REG_NONE  = REG_W'(`RNONE);

  logic [0:0] state;
  logic [0:0] state_nx;
  logic [3:0] ld_cnt;
  logic [3:0] ld_cnt_nx;
  logic [4:0] md_cnt;
  logic       load_hit;
  logic       load_stall;
  logic       md_hit;

  assign load_hit = (E_op == OP_LW) && (E_dstM != REG_NONE) &&
                    ((E_dstM == D_srcA) || (E_dstM == D_srcB));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ld_cnt <= 4'd0;
    end else begin
      state  <= state_nx;
      ld_cnt <= ld_cnt_nx;
    end
  end

  // A redirect squashes the stalled instruction, so the load wait is abandoned.
  always_comb begin
    state_nx  = state;
    ld_cnt_nx = ld_cnt;
    if (E_br_taken) begin
      state_nx  = IDLE;
      ld_cnt_nx = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_hit && LD_MULTI) begin
            state_nx  = LOAD_WAIT;
            ld_cnt_nx = LD_INIT;
          end
        end
        LOAD_WAIT: begin
          if (ld_cnt <= 4'd1) begin
            state_nx  = IDLE;
            ld_cnt_nx = 4'd0;
          end else begin
            ld_cnt_nx = ld_cnt - 4'd1;
          end
        end
        default: begin
          state_nx  = IDLE;
          ld_cnt_nx = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_cnt <= 5'd0;
    end else if (E_md_start) begin
      md_cnt <= MD_INIT;
    end else if (md_cnt != 5'd0) begin
      md_cnt <= md_cnt - 5'd1;
    end
  end

  assign md_busy    = rst_n && (md_cnt != 5'd0);
  assign md_hit     = D_uses_md && ((md_cnt != 5'd0) || E_md_start);
  assign load_stall = (state == LOAD_WAIT) || ((state == IDLE) && load_hit);

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    if (!rst_n) begin
      F_stall = 1'b0;
    end else if (E_br_taken) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
    end else if (load_stall || md_hit) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks on LOAD_LAT=1 and LOAD_LAT=3 instances.
// Rev 1.0 -- initial release.
`ifndef ILW
`define ILW 6'h23
`endif
`ifndef ISW
`define ISW 6'h2b
`endif
`ifndef RNONE
`define RNONE 5'd0
`endif

`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] NOP = 6'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] E_op;
  logic [4:0] E_dstM, D_srcA, D_srcB;
  logic       E_md_start, D_uses_md, E_br_taken;

  logic f1, ds1, db1, eb1, mb1;
  logic f3, ds3, db3, eb3, mb3;
  logic [4:0] o1, o3;
  assign o1 = {f1, ds1, db1, eb1, mb1};
  assign o3 = {f3, ds3, db3, eb3, mb3};

  int passed = 0;
  int total  = 0;
  logic [9:0] exp10;
  logic [4:0] exp5;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.OP_W(6), .REG_W(5), .LOAD_LAT(1), .MD_LAT(4)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .E_op(E_op), .E_dstM(E_dstM), .D_srcA(D_srcA),
    .D_srcB(D_srcB), .E_md_start(E_md_start), .D_uses_md(D_uses_md),
    .E_br_taken(E_br_taken), .F_stall(f1), .D_stall(ds1), .D_bubble(db1),
    .E_bubble(eb1), .md_busy(mb1));

  pipeline_hazard_ctrl #(.OP_W(6), .REG_W(5), .LOAD_LAT(3), .MD_LAT(4)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .E_op(E_op), .E_dstM(E_dstM), .D_srcA(D_srcA),
    .D_srcB(D_srcB), .E_md_start(E_md_start), .D_uses_md(D_uses_md),
    .E_br_taken(E_br_taken), .F_stall(f3), .D_stall(ds3), .D_bubble(db3),
    .E_bubble(eb3), .md_busy(mb3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    E_op = NOP; E_dstM = 5'd0; D_srcA = 5'd0; D_srcB = 5'd0;
    E_md_start = 1'b0; D_uses_md = 1'b0; E_br_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    E_op = `ILW; E_dstM = 5'd7; D_srcA = 5'd7; D_srcB = 5'd7;
    E_md_start = 1'b1; D_uses_md = 1'b1; E_br_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL reset_outputs: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
    total++;
    if ({dut_l3.state, dut_l3.ld_cnt, dut_l3.md_cnt} !== 10'b0)
      $display("FAIL reset_regs: got %b want %b", {dut_l3.state, dut_l3.ld_cnt, dut_l3.md_cnt}, 10'b0);
    else passed++;
    clear_inputs();
    rst_n = 1'b1;
    step();
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL reset_release: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
  endtask

  task automatic test_load_stall();
    step();
    E_op = `ILW; E_dstM = 5'd7; D_srcA = 5'd7; D_srcB = 5'd3;
    #1;
    exp10 = {5'b11010, 5'b11010};
    total++;
    if ({o1, o3} !== exp10) $display("FAIL load_c0: got %b want %b", {o1, o3}, exp10);
    else passed++;
    step();
    E_op = NOP;
    for (int k = 1; k <= 3; k++) begin
      #1;
      exp10 = {5'b00000, (k <= 2) ? 5'b11010 : 5'b00000};
      total++;
      if ({o1, o3} !== exp10) $display("FAIL load_c%0d: got %b want %b", k, {o1, o3}, exp10);
      else passed++;
      exp5 = {(k <= 2) ? 1'b1 : 1'b0, 4'(3 - k)};
      total++;
      if ({dut_l3.state, dut_l3.ld_cnt} !== exp5)
        $display("FAIL load_fsm_c%0d: got %b want %b", k, {dut_l3.state, dut_l3.ld_cnt}, exp5);
      else passed++;
      step();
    end
  endtask

  task automatic test_no_stall();
    E_op = `ILW; E_dstM = `RNONE; D_srcA = `RNONE; D_srcB = `RNONE;
    #1;
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL nostall_rnone: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
    E_op = `ISW; E_dstM = 5'd6; D_srcA = 5'd1; D_srcB = 5'd6;
    #1;
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL nostall_store: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
    E_op = `ILW; E_dstM = 5'd7; D_srcA = 5'd23; D_srcB = 5'd15;
    #1;
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL nostall_width: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
    E_op = `ILW; E_dstM = 5'd6; D_srcA = 5'd1; D_srcB = 5'd6;
    #1;
    exp10 = {5'b11010, 5'b11010};
    total++;
    if ({o1, o3} !== exp10) $display("FAIL load_srcb: got %b want %b", {o1, o3}, exp10);
    else passed++;
    step();
    E_op = NOP;
    step();
    step();
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL load_srcb_done: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
  endtask

  task automatic test_md_stall();
    clear_inputs();
    step();
    E_md_start = 1'b1; D_uses_md = 1'b1;
    #1;
    exp10 = {5'b11010, 5'b11010};
    total++;
    if ({o1, o3} !== exp10) $display("FAIL md_c0: got %b want %b", {o1, o3}, exp10);
    else passed++;
    step();
    E_md_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      exp5 = (k <= 4) ? 5'b11011 : 5'b00000;
      total++;
      if ({o1, o3} !== {exp5, exp5}) $display("FAIL md_c%0d: got %b want %b", k, {o1, o3}, {exp5, exp5});
      else passed++;
      step();
    end
    D_uses_md = 1'b0;
  endtask

  task automatic test_md_reload();
    E_md_start = 1'b1;
    #1;
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL md_nouse: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
    step();
    E_md_start = 1'b0;
    step();
    E_md_start = 1'b1;
    #1;
    total++;
    if ({o1, o3} !== 10'b0000100001) $display("FAIL md_reload_pulse: got %b want %b", {o1, o3}, 10'b0000100001);
    else passed++;
    step();
    E_md_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      exp5 = (k <= 4) ? 5'b00001 : 5'b00000;
      total++;
      if ({o1, o3} !== {exp5, exp5}) $display("FAIL md_reload_c%0d: got %b want %b", k, {o1, o3}, {exp5, exp5});
      else passed++;
      step();
    end
  endtask

  task automatic test_branch();
    E_md_start = 1'b1; D_uses_md = 1'b1;
    E_op = `ILW; E_dstM = 5'd7; D_srcA = 5'd7; D_srcB = 5'd0;
    #1;
    exp10 = {5'b11010, 5'b11010};
    total++;
    if ({o1, o3} !== exp10) $display("FAIL br_setup: got %b want %b", {o1, o3}, exp10);
    else passed++;
    step();
    E_md_start = 1'b0; E_op = NOP; E_br_taken = 1'b1;
    #1;
    exp10 = {5'b00111, 5'b00111};
    total++;
    if ({o1, o3} !== exp10) $display("FAIL br_priority: got %b want %b", {o1, o3}, exp10);
    else passed++;
    step();
    E_br_taken = 1'b0; D_uses_md = 1'b0;
    #1;
    total++;
    if ({dut_l3.state, dut_l3.ld_cnt, dut_l3.md_cnt} !== 10'b0000000011)
      $display("FAIL br_regs: got %b want %b", {dut_l3.state, dut_l3.ld_cnt, dut_l3.md_cnt}, 10'b0000000011);
    else passed++;
    total++;
    if ({o1, o3} !== 10'b0000100001) $display("FAIL br_after: got %b want %b", {o1, o3}, 10'b0000100001);
    else passed++;
    step();
    step();
    step();
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL br_drain: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    E_op = `ILW; E_dstM = 5'd7; D_srcA = 5'd7; E_md_start = 1'b1;
    #1;
    exp10 = {5'b11010, 5'b11010};
    total++;
    if ({o1, o3} !== exp10) $display("FAIL rstmid_c0: got %b want %b", {o1, o3}, exp10);
    else passed++;
    step();
    E_op = NOP; E_md_start = 1'b0;
    #1;
    exp10 = {5'b00001, 5'b11011};
    total++;
    if ({o1, o3} !== exp10) $display("FAIL rstmid_c1: got %b want %b", {o1, o3}, exp10);
    else passed++;
    step();
    rst_n = 1'b0; D_uses_md = 1'b1;
    #1;
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL rstmid_during: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
    step();
    rst_n = 1'b1; D_uses_md = 1'b0;
    #1;
    total++;
    if ({o1, o3} !== 10'b0) $display("FAIL rstmid_after: got %b want %b", {o1, o3}, 10'b0);
    else passed++;
    total++;
    if ({dut_l3.state, dut_l3.ld_cnt, dut_l3.md_cnt} !== 10'b0)
      $display("FAIL rstmid_regs: got %b want %b", {dut_l3.state, dut_l3.ld_cnt, dut_l3.md_cnt}, 10'b0);
    else passed++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_stall();
    test_no_stall();
    test_md_stall();
    test_md_reload();
    test_branch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
